// File: rtl/sw_alloc.sv
// sw_alloc: 4-port switch allocator with per-output head-to-tail locking.
// Define SW_ALLOC_RR_EN for round-robin priority; otherwise the lowest input index wins.
module sw_alloc (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic [7:0]  cmd,
   input  logic [3:0]  empty,
   output logic [3:0]  ack,
   output logic [7:0]  osel,
   output logic [3:0]  ovalid
);
   localparam int         N        = 4;
   localparam logic [1:0] CMD_TAIL = 2'b11;

   typedef enum logic {O_IDLE, O_BUSY} o_state_t;

   o_state_t   state_q [N];
   o_state_t   state_d [N];
   logic [1:0] owner_q [N];
   logic [1:0] owner_d [N];
`ifdef SW_ALLOC_RR_EN
   logic [1:0] ptr_q [N];
   logic [1:0] ptr_d [N];
`endif

   logic [N-1:0] owns_any;
   logic [N-1:0] ereq [N];
   logic         found;
   logic [1:0]   idx;
   logic [1:0]   winner;
   logic [1:0]   own;

   always_comb begin
      owns_any = '0;
      for (int o = 0; o < N; o++) begin
         if (state_q[o] == O_BUSY) owns_any[owner_q[o]] = 1'b1;
      end
   end

   // Only the lowest set request bit counts, and an input holding an output requests nothing.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         ereq[i] = (req[4*i +: 4] & (~req[4*i +: 4] + 4'd1)) & {N{~owns_any[i]}};
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      ack    = '0;
      ovalid = '0;
      osel   = '0;
      found  = 1'b0;
      idx    = '0;
      winner = '0;
      own    = '0;
      for (int o = 0; o < N; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
`ifdef SW_ALLOC_RR_EN
         ptr_d[o]   = ptr_q[o];
`endif
      end

      for (int o = 0; o < N; o++) begin
         own            = owner_q[o];
         osel[2*o +: 2] = own;
         if (state_q[o] == O_BUSY) begin
            ack[own]  = ~empty[own];
            ovalid[o] = ~empty[own];
            if (!empty[own] && cmd[2*own +: 2] == CMD_TAIL) begin
               state_d[o] = O_IDLE;
`ifdef SW_ALLOC_RR_EN
               ptr_d[o]   = own + 2'd1;
`endif
            end
         end else begin
            found  = 1'b0;
            winner = '0;
            for (int k = 0; k < N; k++) begin
`ifdef SW_ALLOC_RR_EN
               idx = ptr_q[o] + 2'(k);
`else
               idx = 2'(k);
`endif
               if (!found && ereq[idx][o]) begin
                  found  = 1'b1;
                  winner = idx;
               end
            end
            if (found) begin
               state_d[o] = O_BUSY;
               owner_d[o] = winner;
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so all outputs advance on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: the per-output arrays are a handful of flops, so every entry is reset explicitly.
      if (rst) begin
         for (int o = 0; o < N; o++) begin
            state_q[o] <= O_IDLE;
            owner_q[o] <= '0;
`ifdef SW_ALLOC_RR_EN
            ptr_q[o]   <= '0;
`endif
         end
      end else begin
         for (int o = 0; o < N; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
`ifdef SW_ALLOC_RR_EN
            ptr_q[o]   <= ptr_d[o];
`endif
         end
      end
   end
endmodule

// File: tb/tb_sw_alloc.sv
// Self-checking bench for sw_alloc: packet-level upstream model plus an allocation reference model.
// Directed scenarios first, then randomized traffic with random FIFO stalls.
module tb_sw_alloc;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic [7:0]  cmd;
   logic [3:0]  empty;
   logic [3:0]  ack;
   logic [7:0]  osel;
   logic [3:0]  ovalid;

   always #5 clk = ~clk;

   sw_alloc dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .cmd    (cmd),
      .empty  (empty),
      .ack    (ack),
      .osel   (osel),
      .ovalid (ovalid)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Upstream packet sources: destination, flits left, head-pending flag, junk request bits.
   bit         act   [4];
   int         dst   [4];
   int         left  [4];
   bit         first [4];
   logic [3:0] extra [4];
   logic [3:0] hold_empty;
   bit         rand_empty;
   bit         spawn;
   int         order [$];

   // Reference model: which input owns each output (-1 free), which output each input holds.
   int         own   [4];
   int         last  [4];
   int         pri   [4];
   int         holds [4];
   logic [3:0] e_ack;
   logic [3:0] e_ovalid;
   logic [7:0] e_osel;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int low_bit(input logic [3:0] v);
      for (int b = 0; b < 4; b++) if (v[b]) return b;
      return -1;
   endfunction

   function automatic logic [15:0] pack_order();
      logic [15:0] v = '0;
      foreach (order[k]) v = {v[11:0], 4'(order[k] + 1)};
      return v;
   endfunction

   function automatic bit busy();
      for (int i = 0; i < 4; i++) if (act[i] || own[i] >= 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic reset_model();
      for (int k = 0; k < 4; k++) begin
         own[k] = -1; last[k] = 0; pri[k] = 0; holds[k] = -1; act[k] = 1'b0;
      end
   endtask

   task automatic start_pkt(input int i, input int d, input int len, input logic [3:0] x);
      act[i]   = 1'b1;
      dst[i]   = d;
      left[i]  = len;
      first[i] = 1'b1;
      extra[i] = x & ~((4'b0010 << d) - 4'b0001);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++) begin
         if (act[i]) begin
            req[4*i +: 4] = (4'b0001 << dst[i]) | extra[i];
            empty[i]      = hold_empty[i] | (rand_empty && $urandom_range(3) == 0);
            if (empty[i])        cmd[2*i +: 2] = 2'b00;
            else if (first[i])   cmd[2*i +: 2] = 2'b10;
            else if (left[i] == 1) cmd[2*i +: 2] = 2'b11;
            else                 cmd[2*i +: 2] = 2'b01;
         end else begin
            req[4*i +: 4] = 4'b0000;
            empty[i]      = 1'b1;
            cmd[2*i +: 2] = 2'b00;
         end
      end
   endtask

   task automatic model_outputs();
      e_ack    = '0;
      e_ovalid = '0;
      for (int o = 0; o < 4; o++) begin
         e_osel[2*o +: 2] = 2'(last[o]);
         if (own[o] >= 0 && !empty[own[o]]) begin
            e_ack[own[o]] = 1'b1;
            e_ovalid[o]   = 1'b1;
         end
      end
   endtask

   task automatic model_update();
      bit free [4];
      int best, bestd, d;
      if (rst) begin
         reset_model();
         return;
      end
      for (int i = 0; i < 4; i++) free[i] = (holds[i] < 0);
      for (int o = 0; o < 4; o++) begin
         if (own[o] >= 0) begin
            if (e_ack[own[o]] && cmd[2*own[o] +: 2] == 2'b11) begin
`ifdef SW_ALLOC_RR_EN
               pri[o] = (own[o] + 1) % 4;
`endif
               holds[own[o]] = -1;
               own[o]        = -1;
            end
         end else begin
            best  = -1;
            bestd = 99;
            for (int i = 0; i < 4; i++) begin
               d = (i - pri[o] + 4) % 4;
               if (free[i] && low_bit(req[4*i +: 4]) == o && d < bestd) begin
                  best  = i;
                  bestd = d;
               end
            end
            if (best >= 0) begin
               own[o]      = best;
               last[o]     = best;
               holds[best] = o;
            end
         end
      end
   endtask

   task automatic upstream_update();
      for (int i = 0; i < 4; i++) begin
         if (act[i] && e_ack[i]) begin
            if (first[i]) order.push_back(i);
            first[i] = 1'b0;
            left[i]--;
            if (left[i] == 0) act[i] = 1'b0;
         end
      end
      if (spawn) begin
         for (int i = 0; i < 4; i++) begin
            if (!act[i] && $urandom_range(2) == 0)
               start_pkt(i, $urandom_range(3), $urandom_range(5, 2), 4'($urandom));
         end
      end
   endtask

   task automatic cycle();
      model_outputs();
      @(negedge clk);
      check("ack", {12'd0, ack}, {12'd0, e_ack});
      check("ovalid", {12'd0, ovalid}, {12'd0, e_ovalid});
      check("osel", {8'd0, osel}, {8'd0, e_osel});
      @(posedge clk);
      model_update();
      upstream_update();
      #1;
      drive_inputs();
   endtask

   task automatic drain(input int max);
      int k = 0;
      while (busy() && k < max) begin
         cycle();
         k++;
      end
      check("drain_timeout", {15'd0, busy()}, 16'd0);
   endtask

   initial begin
      rst        = 1'b1;
      rand_empty = 1'b0;
      spawn      = 1'b0;
      hold_empty = '0;
      reset_model();
      drive_inputs();
      @(posedge clk);
      #1;
      check("rst_ack", {12'd0, ack}, 16'd0);
      check("rst_osel", {8'd0, osel}, 16'd0);
      cycle();
      rst = 1'b0;

      // Single packet: input 1 to output 2, three flits.
      start_pkt(1, 2, 3, 4'b0000);
      drive_inputs();
      drain(20);
      check("single_ack_after", {12'd0, ack}, 16'd0);

      // Contention on output 0 right after reset: 0, 2, 3 in either priority mode.
      order.delete();
      start_pkt(0, 0, 3, 4'b0000);
      start_pkt(2, 0, 2, 4'b0000);
      start_pkt(3, 0, 2, 4'b0000);
      drive_inputs();
      drain(40);
      check("contention_order", pack_order(), 16'h0134);

      // Priority wrap: input 2 alone moves ptr[0] to 3, then inputs 0 and 3 collide.
      start_pkt(2, 0, 2, 4'b0000);
      drive_inputs();
      drain(20);
      order.delete();
      start_pkt(0, 0, 2, 4'b0000);
      start_pkt(3, 0, 2, 4'b0000);
      drive_inputs();
      drain(40);
`ifdef SW_ALLOC_RR_EN
      check("rr_wrap_order", pack_order(), 16'h0041);
`else
      check("fixed_order", pack_order(), 16'h0014);
`endif

      // Parallel paths: all four outputs granted on one edge.
      start_pkt(0, 2, 4, 4'b0000);
      start_pkt(1, 3, 4, 4'b0000);
      start_pkt(2, 0, 4, 4'b0000);
      start_pkt(3, 1, 4, 4'b0000);
      drive_inputs();
      cycle();
      #1;
      check("parallel_ack", {12'd0, ack}, 16'h000f);
      check("parallel_osel", {8'd0, osel}, {8'd0, 2'd1, 2'd0, 2'd3, 2'd2});
      drain(20);

      // Empty stall mid-packet on input 2 (output 1).
      start_pkt(2, 1, 5, 4'b0000);
      drive_inputs();
      cycle();
      cycle();
      hold_empty = 4'b0100;
      drive_inputs();
      cycle();
      #1;
      check("stall_ack", {12'd0, ack}, 16'd0);
      check("stall_osel", {14'd0, osel[3:2]}, 16'd2);
      cycle();
      hold_empty = 4'b0000;
      drive_inputs();
      drain(20);

      // Reset during body flits drops ownership.
      start_pkt(1, 3, 6, 4'b0000);
      drive_inputs();
      cycle();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("rst_mid_ack", {12'd0, ack}, 16'd0);
      check("rst_mid_ovalid", {12'd0, ovalid}, 16'd0);

      // Malformed request 0110 from input 0: only output 1 may be granted.
      start_pkt(0, 1, 3, 4'b0100);
      drive_inputs();
      check("malformed_req", req, 16'h0006);
      cycle();
      #1;
      check("malformed_ovalid", {12'd0, ovalid}, 16'h0002);
      drain(20);

      // Randomized traffic with random stalls and junk upper request bits.
      rand_empty = 1'b1;
      spawn      = 1'b1;
      for (int n = 0; n < 2000; n++) cycle();
      spawn = 1'b0;
      drain(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sw_alloc.md
# sw_alloc

Switch allocator for the 4-port switch, directly downstream of the per-input buffer managers. It takes each input's registered one-hot destination request, arbitrates each output port independently, and returns a per-input `ack` that the buffer manager uses directly as its FIFO read enable. Each output stays locked to its winning input from head flit to tail flit. The allocator also drives the crossbar select and valid for every output.

## Interface
- `N`, 4: number of ports. Fixed at 4; port index width is 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  16  input i's one-hot destination vector at `[4i+3:4i]`; all-zero means no request.
- `cmd`  in  8  input i's FIFO-output flit command at `[2i+1:2i]`: 10 = head, 11 = tail, 01 = body, 00 = none.
- `empty`  in  4  input i's FIFO is empty.
- `ack`  out  4  grant and read enable for input i.
- `osel`  out  8  crossbar select for output o at `[2o+1:2o]`; the value is the owning input index.
- `ovalid`  out  4  output o carries a flit this cycle.

## Operation
- Each output o has its own FSM with state O_IDLE or O_BUSY, plus a 2-bit `owner[o]` register and a 2-bit `ptr[o]` priority pointer.
- Effective request: `ereq[i][o]` = bit o of `req[i]` is the lowest set bit of `req[i]`, and input i is not currently the owner of any output.
  - A multi-bit `req` only requests its lowest set bit.
  - An input never holds two outputs at once.
- O_IDLE behaviour:
  - If any `ereq[*][o]` is set, pick a winner, register `owner[o]` = winner, and move to O_BUSY.
  - The winner is the first requester found scanning i = ptr, ptr+1, … mod 4.
  - Outputs arbitrate in the same cycle. They cannot collide, because each input's effective request is one-hot.
- O_BUSY behaviour:
  - `ack[owner]` = ~`empty[owner]`.
  - `ovalid[o]` = `ack[owner]`.
  - `osel[o]` = `owner[o]`.
  - Release condition: `ack[owner]` is 1 and `cmd[owner]` = 11 (the tail is being read). On release, move to O_IDLE next cycle and set `ptr[o]` = owner+1 (mod 4, wraps 3→0).
- `ack` and `ovalid` are combinational from the registered state and `empty`/`cmd`. No input is ever acked while it owns nothing.
- `osel[o]` holds its last owner while idle. `ovalid[o]` = 0 while idle.

## Timing
- Reset values:
  - All FSMs in O_IDLE.
  - `owner` = 0, `ptr` = 0.
  - `ack` = 0, `ovalid` = 0, `osel` = 0.
- Grant latency: a request visible in cycle t while the output is O_IDLE gives `ack` high in cycle t+1, provided the FIFO is non-empty.
- Empty stall: when `empty` rises mid-packet, `ack`/`ovalid` drop in the same cycle while ownership holds. They resume when data returns.
- Tail handling:
  - The tail is read in cycle t, with `ack` high.
  - `ack` is low in t+1.
  - The output can grant a new input in t+1. The upstream `req` has already cleared on the same edge, so no stale regrant occurs.
- Simultaneous release and new request on the same output: the new request is evaluated the cycle after release, never in the release cycle.
- `rst` mid-packet: all ownership is dropped immediately and `ack` = 0 in the following cycle. Upstream state is the upstream block's responsibility.

## Configuration
- `SW_ALLOC_RR_EN` defined: round-robin, with `ptr[o]` updated on each release as above.
- `SW_ALLOC_RR_EN` undefined:
  - `ptr` is removed.
  - Fixed priority: the lowest input index wins.
  - All other behaviour is identical.

## Test plan
- Single packet: after reset, input 1 `req` = 0100, FIFO holding head/body/tail.
  - `ack` = 0010 from the next cycle for 3 cycles.
  - `osel[5:4]` = 01, `ovalid` = 0100.
  - After the tail, `ack` = 0000.
- Contention: inputs 0, 2, 3 all request output 0 at once.
  - With RR: packets are served in order 0, 2, 3, with one-cycle gaps between them.
  - Without RR: input 0 is served first, then 2, then 3.
- RR wrap: `ptr[0]` = 3 (set by prior traffic); inputs 0 and 3 then request together → input 3 is granted, then input 0.
- Parallel paths: inputs 0→2, 1→3, 2→0, 3→1 simultaneously → all four `ack` bits high in the same cycle, `osel` = {2'd1, 2'd0, 2'd3, 2'd2}.
- Empty stall: `empty[2]` pulses high for 2 cycles mid-packet → `ack[2]` and `ovalid` for its output are low exactly in those cycles, with `owner` unchanged.
- Reset mid-packet and malformed request:
  - `rst` during body flits → `ack` = 0 next cycle and all outputs idle.
  - `req` = 0110 → only output 1 is granted.
